// File: rtl/mac_stream_sequencer.sv
// mac_stream_sequencer: feeds vectors and weights to an external MAC and queues its results.
// Defining MAC_SEQ_PERF_EN adds the bubble_cnt output.
module mac_stream_sequencer #(
  parameter int LOG2_NO_VECS = 2,
  parameter int BW = 16,
  parameter int BW_W = 2,
  parameter int NUM_CYC = 32,
  parameter int MAC_LAT = 4,
  parameter int RES_DEPTH = 4,
  localparam int VEC = 1 << LOG2_NO_VECS,
  localparam int CW = $clog2(NUM_CYC),
  localparam int AW = $clog2(RES_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  output logic in_rdy,
  input  logic [VEC-1:0][BW-1:0] in_data,
  input  logic w_wr_en,
  input  logic [CW-1:0] w_wr_addr,
  input  logic [VEC-1:0][BW_W-1:0] w_wr_data,
  output logic mac_new_sum,
  output logic [VEC-1:0][BW-1:0] mac_data_in,
  output logic [VEC-1:0][BW_W-1:0] mac_w_vec,
  input  logic [BW-1:0] mac_data_out,
  output logic out_vld,
  input  logic out_rdy,
  output logic [BW-1:0] out_data
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  localparam logic [CW-1:0] LAST = CW'(NUM_CYC - 1);
  logic [VEC-1:0][BW_W-1:0] w_mem [NUM_CYC];
  logic [BW-1:0] fifo [RES_DEPTH];
  logic [CW-1:0] cyc_cnt;
  logic [AW:0] inflight, occ;
  logic [AW-1:0] wp, rp;
  logic [MAC_LAT:0] tag;
  logic rdy_en, xfer, start, push, pop, wr;
  assign xfer = in_vld && in_rdy;
  assign start = xfer && cyc_cnt == '0;
  assign push = tag[MAC_LAT];
  assign pop = out_vld && out_rdy;
  assign wr = push && (!occ[AW] || pop);
  // a new sum is admitted only if its result is guaranteed a FIFO slot
  assign in_rdy = rdy_en && (cyc_cnt != '0 || ({1'b0, occ} + {1'b0, inflight}) < (AW+2)'(RES_DEPTH));
  assign out_vld = occ != '0;
  assign out_data = out_vld ? fifo[rp] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cyc_cnt <= '0;
      inflight <= '0;
      occ <= '0;
      wp <= '0;
      rp <= '0;
      tag <= '0;
      rdy_en <= 1'b0;
      mac_new_sum <= 1'b0;
      mac_data_in <= '0;
      mac_w_vec <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (xfer) cyc_cnt <= cyc_cnt == LAST ? '0 : cyc_cnt + 1'b1;
      mac_new_sum <= start;
      mac_data_in <= xfer ? in_data : '0;
      mac_w_vec <= xfer ? w_mem[cyc_cnt] : '0;
      tag <= {tag[MAC_LAT-1:0], xfer && cyc_cnt == LAST};
      inflight <= inflight + (AW+1)'(start) - (AW+1)'(push);
      occ <= occ + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk) begin
    if (w_wr_en) w_mem[w_wr_addr] <= w_wr_data;
    if (wr) fifo[wp] <= mac_data_out;
  end
`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bubble_cnt <= '0;
    else if (cyc_cnt != '0 && !xfer && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
`endif
endmodule

// File: doc/mac_stream_sequencer.md
MAC_STREAM_SEQUENCER -- requirements
Module: mac_stream_sequencer

Interface
REQ-001 SHALL have parameter LOG2_NO_VECS, default 2: log2 of vector lanes per cycle (VEC = 1 << LOG2_NO_VECS).
REQ-002 SHALL have parameter BW, default 16: data and result bit width, signed.
REQ-003 SHALL have parameter BW_W, default 2: weight bit width, signed.
REQ-004 SHALL have parameter NUM_CYC, default 32: vectors per sum, at least 2.
REQ-005 SHALL have parameter MAC_LAT, default 4: cycles from the last mac_data_in vector of a sum until its result is valid on mac_data_out.
REQ-006 SHALL have parameter RES_DEPTH, default 4: result FIFO depth, a power of 2.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_vld / in_rdy  in / out  1 / 1  upstream vector handshake; a transfer occurs when both are high.
REQ-010 in_data  in  VEC x BW  upstream vector.
REQ-011 w_wr_en, w_wr_addr, w_wr_data  in  1, clog2(NUM_CYC), VEC x BW_W  weight table write port.
REQ-012 mac_new_sum, mac_data_in, mac_w_vec  out  1, VEC x BW, VEC x BW_W  drive to the MAC.
REQ-013 mac_data_out  in  BW  MAC result.
REQ-014 out_vld / out_rdy / out_data  out / in / out  1 / 1 / BW  result handshake.

Function
REQ-015 SHALL keep a cycle counter cyc_cnt in 0..NUM_CYC-1; it SHALL advance only on an input transfer and SHALL wrap from NUM_CYC-1 to 0.
REQ-016 On an input transfer, SHALL register in_data onto mac_data_in and weight[cyc_cnt] onto mac_w_vec on the next edge: one-cycle latency.
REQ-017 SHALL assert mac_new_sum for exactly the registered cycle of a transfer made with cyc_cnt==0.
REQ-018 On a cycle with no transfer, SHALL drive mac_data_in=0, mac_w_vec=0 and mac_new_sum=0, so a bubble adds zero to the sum.
REQ-019 SHALL tag a transfer made with cyc_cnt==NUM_CYC-1 as last; SHALL delay the tag MAC_LAT cycles past its mac_* cycle through a shift register.
REQ-020 When the delayed tag is high, SHALL push mac_data_out into the result FIFO in that same cycle.
REQ-021 SHALL keep inflight, the count of sums started but not yet pushed.
REQ-022 At cyc_cnt==0, in_rdy SHALL be high only if FIFO occupancy + inflight < RES_DEPTH.
REQ-023 At cyc_cnt!=0, in_rdy SHALL be high unconditionally, so a started sum never waits on FIFO space.
REQ-024 out_vld SHALL equal FIFO not-empty; out_data SHALL be the FIFO head; a pop SHALL occur when out_vld && out_rdy.
REQ-025 A simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-026 A weight write SHALL take effect on the next edge; a read of the same address in the same cycle SHALL return the old value.
REQ-027 SHALL contain no arithmetic on data; the MAC does all multiply/add.

Reset
REQ-028 While rst_n is low, SHALL clear cyc_cnt, inflight, the tag pipe and the FIFO pointers, and SHALL drive in_rdy=0, out_vld=0, out_data=0, mac_new_sum=0, mac_data_in=0, mac_w_vec=0.
REQ-029 The weight table SHALL NOT be reset.
REQ-030 A reset mid-sum SHALL discard the partial sum and all in-flight results.
REQ-031 in_rdy SHALL go high no earlier than the first edge after rst_n deasserts.

Configuration
REQ-032 With MAC_SEQ_PERF_EN defined, SHALL add output bubble_cnt[31:0]: a saturating count of cycles with cyc_cnt!=0 and no transfer, cleared by reset.
REQ-033 Without MAC_SEQ_PERF_EN, the bubble_cnt port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification (NUM_CYC=4, VEC=4, MAC_LAT=3, RES_DEPTH=2, bench MAC model)
REQ-034 Weights all +1, 4 vectors all lanes 1, in_vld held high -> mac_new_sum high only on the first mac cycle; out_data=16, pushed 3 cycles after the 4th mac cycle.
REQ-035 Same stream with in_vld low for 2 cycles after vector 2 -> two zero mac cycles; out_data=16 still; bubble_cnt=2 with the macro defined.
REQ-036 out_rdy=0 for 3 sums -> in_rdy low at cyc_cnt==0 of sum 3; one pop reopens it; out_data order is sum1, sum2.
REQ-037 Weight lane0=-1, others 0, data lane0=5 -> out_data=-20 (0xFFEC).
REQ-038 rst_n pulsed low after vector 2 -> all outputs 0; the next full sum yields the correct result and no stale push.
